// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: START/STOP framed bit stream sampled on scl rising edges,
// assembled into WIDTH-bit words and queued in a first-word-fall-through FIFO.
module sipo_rx #(
    parameter int WIDTH      = 8,
    parameter int LSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    // [0] first sync flop, [1] synchronized level, [2] previous level for edge detection
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    logic             scl_s, scl_p, sda_s, sda_p;
    logic             start_ev, stop_ev, rise_ev;
    logic [WIDTH-1:0] shift_ext;
    logic [WIDTH-2:0] sr_shift;
    logic             push, pop, full, accept;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl};
        sda_pipe_d = {sda_pipe_q[1:0], sda};
        scl_s = scl_pipe_q[1];
        scl_p = scl_pipe_q[2];
        sda_s = sda_pipe_q[1];
        sda_p = sda_pipe_q[2];
        start_ev = sda_p & ~sda_s & scl_p & scl_s;
        stop_ev  = ~sda_p & sda_s & scl_p & scl_s;
        rise_ev  = ~scl_p & scl_s;
    end

    // The completed word is the shift register extended by the bit arriving now.
    always_comb begin
        if (LSB_FIRST != 0) begin
            shift_ext = {sda_s, sr_q};
            sr_shift  = shift_ext[WIDTH-1:1];
        end else begin
            shift_ext = {sr_q, sda_s};
            sr_shift  = shift_ext[WIDTH-2:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_pipe_q  <= '1;
            sda_pipe_q  <= '1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            scl_pipe_q  <= scl_pipe_d;
            sda_pipe_q  <= sda_pipe_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ev) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (rise_ev) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        push      = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        sr_d      = sr_shift;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (stop_ev) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (start_ev) begin
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        pop        = valid & ready;
        full       = (count_q == FULL_CNT);
        accept     = push & (~full | pop);
        overflow_d = push & full & ~pop;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        if (accept) mem_d[wr_ptr_q] = shift_ext;
        wr_ptr_d = wr_ptr_q + PW'(accept);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW + 1)'(accept) - (PW + 1)'(pop);
    end

    always_comb begin
        busy      = (state_q == SHIFT);
        valid     = (count_q != '0);
        data_out  = valid ? mem_q[rd_ptr_q] : '0;
        frame_err = frame_err_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: LSB-first and MSB-first instances share one bus; a queue model of the
// expected FIFO contents is checked every clock, plus literal word and pulse-count checks.
module tb_sipo_rx;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scl = 1'b1;
    logic sda = 1'b1;
    logic ready = 1'b1;

    logic [W-1:0] dout_l, dout_m;
    logic valid_l, valid_m, busy_l, busy_m, ferr_l, ferr_m, ovf_l, ovf_m;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W), .LSB_FIRST(1), .FIFO_DEPTH(D)) dut_l (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .data_out(dout_l), .valid(valid_l),
        .ready(ready), .busy(busy_l), .frame_err(ferr_l), .overflow(ovf_l));

    sipo_rx #(.WIDTH(W), .LSB_FIRST(0), .FIFO_DEPTH(D)) dut_m (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .data_out(dout_m), .valid(valid_m),
        .ready(ready), .busy(busy_m), .frame_err(ferr_m), .overflow(ovf_m));

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] ql[$], qm[$], got_l[$], got_m[$], exp_q[$];
    int ferr_seen_l = 0, ferr_seen_m = 0, ovf_seen_l = 0, ovf_seen_m = 0;
    int exp_ferr = 0, exp_ovf_l = 0, exp_ovf_m = 0;
    int bcnt = 0;
    logic [W-1:0] wl = '0, wm = '0;
    bit in_frame = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model queues; a pop is taken when the model holds a word and ready is high.
    always @(negedge clk) begin
        if (rst) begin
            chk("valid_l", {31'd0, valid_l}, {31'd0, ql.size() != 0});
            chk("valid_m", {31'd0, valid_m}, {31'd0, qm.size() != 0});
            chk("data_l", {24'd0, dout_l}, (ql.size() != 0) ? {24'd0, ql[0]} : 32'd0);
            chk("data_m", {24'd0, dout_m}, (qm.size() != 0) ? {24'd0, qm[0]} : 32'd0);
            if (ready && ql.size() != 0) begin got_l.push_back(ql[0]); ql.pop_front(); end
            if (ready && qm.size() != 0) begin got_m.push_back(qm[0]); qm.pop_front(); end
            ferr_seen_l += int'(ferr_l);
            ferr_seen_m += int'(ferr_m);
            ovf_seen_l  += int'(ovf_l);
            ovf_seen_m  += int'(ovf_m);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Bus drives land 2 time units after a clock edge; returns 1 unit after the third following edge.
    task automatic step(input logic s, input logic d);
        @(posedge clk);
        #2;
        scl = s;
        sda = d;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic void model_push();
        if (ql.size() < D) ql.push_back(wl); else exp_ovf_l++;
        if (qm.size() < D) qm.push_back(wm); else exp_ovf_m++;
    endfunction

    task automatic bit_c(input logic b, input bit pulse_rdy);
        step(1'b0, sda);
        step(1'b0, b);
        if (!pulse_rdy) begin
            step(1'b1, b);
        end else begin
            @(posedge clk); #2; scl = 1'b1;
            @(posedge clk); @(posedge clk); #2; ready = 1'b1;
            @(posedge clk); #1;
        end
        if (in_frame) begin
            wl[bcnt] = b;
            wm[W-1-bcnt] = b;
            bcnt++;
            if (bcnt == W) begin
                model_push();
                bcnt = 0;
                wl = '0;
                wm = '0;
            end
        end
        if (pulse_rdy) begin #1; ready = 1'b0; end
    endtask

    task automatic start_c();
        if (in_frame && bcnt != 0) exp_ferr++;
        step(1'b1, 1'b0);
        in_frame = 1'b1;
        bcnt = 0;
        wl = '0;
        wm = '0;
    endtask

    task automatic rstart_c();
        if (sda == 1'b0) bit_c(1'b1, 1'b0);
        start_c();
    endtask

    task automatic stop_c();
        if (sda == 1'b1) start_c();
        step(1'b1, 1'b1);
        if (bcnt != 0) exp_ferr++;
        in_frame = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] v, input bit pulse_last);
        for (int i = 0; i < W; i++) bit_c(v[i], pulse_last && (i == W - 1));
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic new_scenario();
        got_l.delete(); got_m.delete();
        ferr_seen_l = 0; ferr_seen_m = 0; ovf_seen_l = 0; ovf_seen_m = 0;
        exp_ferr = 0; exp_ovf_l = 0; exp_ovf_m = 0;
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, "_ferr_l"}, ferr_seen_l, exp_ferr);
        chk({nm, "_ferr_m"}, ferr_seen_m, exp_ferr);
        chk({nm, "_ovf_l"}, ovf_seen_l, exp_ovf_l);
        chk({nm, "_ovf_m"}, ovf_seen_m, exp_ovf_m);
    endtask

    task automatic drain();
        int k = 0;
        while ((ql.size() != 0 || qm.size() != 0) && k < 50) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_done", {31'd0, (ql.size() == 0 && qm.size() == 0)}, 32'd1);
        settle();
    endtask

    task automatic chk_list(input string nm, input logic [W-1:0] got[$], input logic [W-1:0] exp[$]);
        chk({nm, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk({nm, "_word"}, {24'd0, got[i]}, {24'd0, exp[i]});
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_l", {31'd0, valid_l}, 32'd0);
        chk("rst_busy_l", {31'd0, busy_l}, 32'd0);
        chk("rst_data_m", {24'd0, dout_m}, 32'd0);
        @(posedge clk); #2; rst = 1'b1;
        settle();
        chk("post_rst_busy_m", {31'd0, busy_m}, 32'd0);
        chk("post_rst_valid_l", {31'd0, valid_l}, 32'd0);

        // 0xA5 is its own bit reversal
        new_scenario();
        start_c();
        chk("start_busy_l", {31'd0, busy_l}, 32'd1);
        chk("start_busy_m", {31'd0, busy_m}, 32'd1);
        send_word(8'hA5, 1'b0);
        stop_c();
        drain();
        chk("stop_busy_l", {31'd0, busy_l}, 32'd0);
        chk("stop_busy_m", {31'd0, busy_m}, 32'd0);
        chk_counts("a5");
        chk("a5_ferr_lit", ferr_seen_l, 0);
        exp_q = '{8'hA5}; chk_list("a5_l", got_l, exp_q);
        exp_q = '{8'hA5}; chk_list("a5_m", got_m, exp_q);

        // bits 1,1,0,0,0,0,0,0
        new_scenario();
        start_c();
        send_word(8'h03, 1'b0);
        stop_c();
        drain();
        chk_counts("c0");
        exp_q = '{8'h03}; chk_list("c0_l", got_l, exp_q);
        exp_q = '{8'hC0}; chk_list("c0_m", got_m, exp_q);

        // five words into a four-deep FIFO with the consumer stalled
        new_scenario();
        ready = 1'b0;
        start_c();
        for (int v = 1; v <= 5; v++) send_word(W'(v), 1'b0);
        stop_c();
        settle();
        chk_counts("ovf");
        chk("ovf_lit_l", ovf_seen_l, 1);
        chk("ovf_lit_m", ovf_seen_m, 1);
        chk("ovf_held_valid", {31'd0, valid_l}, 32'd1);
        @(posedge clk); #2; ready = 1'b1;
        drain();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04}; chk_list("ovf_l", got_l, exp_q);
        exp_q = '{8'h80, 8'h40, 8'hC0, 8'h20}; chk_list("ovf_m", got_m, exp_q);

        // partial word closed by STOP
        new_scenario();
        start_c();
        bit_c(1'b1, 1'b0); bit_c(1'b0, 1'b0); bit_c(1'b1, 1'b0);
        stop_c();
        settle();
        chk_counts("partial");
        chk("partial_ferr_lit", ferr_seen_l, 1);
        chk("partial_no_word", got_l.size(), 0);

        // partial word abandoned by repeated START, then a full word
        new_scenario();
        start_c();
        bit_c(1'b1, 1'b0); bit_c(1'b0, 1'b0); bit_c(1'b1, 1'b0);
        rstart_c();
        send_word(8'h3C, 1'b0);
        stop_c();
        drain();
        chk_counts("rstart");
        chk("rstart_ferr_lit", ferr_seen_m, 1);
        exp_q = '{8'h3C}; chk_list("rstart_l", got_l, exp_q);
        exp_q = '{8'h3C}; chk_list("rstart_m", got_m, exp_q);

        // full FIFO, pop coincides with the push of the fifth word
        new_scenario();
        ready = 1'b0;
        start_c();
        send_word(8'h11, 1'b0); send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0); send_word(8'h44, 1'b0);
        send_word(8'h55, 1'b1);
        stop_c();
        settle();
        chk_counts("coinc");
        chk("coinc_ovf_lit", ovf_seen_l, 0);
        chk("coinc_full_valid", {31'd0, valid_m}, 32'd1);
        @(posedge clk); #2; ready = 1'b1;
        drain();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}; chk_list("coinc_l", got_l, exp_q);
        exp_q = '{8'h88, 8'h44, 8'hCC, 8'h22, 8'hAA}; chk_list("coinc_m", got_m, exp_q);

        // reset mid-frame with words buffered
        new_scenario();
        ready = 1'b0;
        start_c();
        send_word(8'h0F, 1'b0); send_word(8'hF0, 1'b0);
        bit_c(1'b1, 1'b0); bit_c(1'b0, 1'b0); bit_c(1'b1, 1'b0); bit_c(1'b1, 1'b0);
        chk("prerst_valid_l", {31'd0, valid_l}, 32'd1);
        chk("prerst_busy_l", {31'd0, busy_l}, 32'd1);
        @(posedge clk); #2; rst = 1'b0;
        #1;
        chk("midrst_valid_l", {31'd0, valid_l}, 32'd0);
        chk("midrst_data_l", {24'd0, dout_l}, 32'd0);
        chk("midrst_busy_l", {31'd0, busy_l}, 32'd0);
        chk("midrst_valid_m", {31'd0, valid_m}, 32'd0);
        chk("midrst_data_m", {24'd0, dout_m}, 32'd0);
        chk("midrst_busy_m", {31'd0, busy_m}, 32'd0);
        ql.delete(); qm.delete();
        in_frame = 1'b0; bcnt = 0;
        scl = 1'b1; sda = 1'b1;
        repeat (3) @(posedge clk);
        #2; rst = 1'b1; ready = 1'b1;
        settle();
        new_scenario();
        chk("postrst_busy_l", {31'd0, busy_l}, 32'd0);
        start_c();
        send_word(8'h5A, 1'b0);
        stop_c();
        drain();
        chk_counts("rst");
        exp_q = '{8'h5A}; chk_list("rst_l", got_l, exp_q);
        exp_q = '{8'h5A}; chk_list("rst_m", got_m, exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
